demux_router_n: RTL and testbench



---
 rtl/demux_router_n.sv | 93 +++++++++
 tb/tb_demux_router_n.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux_router_n.sv
// demux_router_n: 1:N demultiplexer with one registered slot per output and valid/ready handshakes.
// Optional broadcast mode is enabled by defining DEMUX_BCAST_EN (adds the in_bcast input).
module demux_router_n #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_OUT  = 4,
  parameter int unsigned SEL_W  = $clog2(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
`ifdef DEMUX_BCAST_EN
  input  logic                    in_bcast,
`endif
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic                    sel_err
);

  logic [N_OUT-1:0]        valid_q, valid_d;
  logic [N_OUT*DATA_W-1:0] data_q, data_d;
  logic                    sel_err_q, sel_err_d;
  logic [N_OUT-1:0]        sel_hit, slot_free, load;
  logic                    sel_ok, in_fire, bcast;

  // A slot can take a word if it is empty or is being drained this cycle.
  assign slot_free = ~valid_q | out_ready;

`ifdef DEMUX_BCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < N_OUT; i++) begin
      sel_hit[i] = (in_sel == SEL_W'(i));
    end
    sel_ok = |sel_hit;

    if (bcast) begin
      in_ready = &slot_free;
    end else if (sel_ok) begin
      in_ready = |(sel_hit & slot_free);
    end else begin
      in_ready = 1'b1;
    end

    in_fire = in_valid & in_ready;

    if (!in_fire) begin
      load = '0;
    end else if (bcast) begin
      load = '1;
    end else begin
      load = sel_hit;
    end

    // Out-of-range words are swallowed; the flag reports the drop one cycle later.
    sel_err_d = in_fire & ~bcast & ~sel_ok;

    valid_d = valid_q;
    data_d  = data_q;
    for (int i = 0; i < N_OUT; i++) begin
      if (load[i]) begin
        valid_d[i]                    = 1'b1;
        data_d[i*DATA_W +: DATA_W]    = in_data;
      end else if (valid_q[i] && out_ready[i]) begin
        valid_d[i]                    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= '0;
      data_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_demux_router_n.sv
// Bench for demux_router_n: queue-based model checked every cycle on a 4-channel instance,
// plus directed literal checks (including out-of-range select on a 3-channel instance).
module tb_demux_router_n;

  logic        clk;
  logic        rst;
  logic        chk_en;
  int          checks;
  int          fails;

  // 4-channel instance
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic        sel_err;

  // 3-channel instance
  logic        d3_in_valid;
  logic        d3_in_ready;
  logic [7:0]  d3_in_data;
  logic [1:0]  d3_in_sel;
  logic [2:0]  d3_out_valid;
  logic [2:0]  d3_out_ready;
  logic [23:0] d3_out_data;
  logic        d3_sel_err;

  demux_router_n #(.DATA_W(8), .N_OUT(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel_err   (sel_err)
  );

  demux_router_n #(.DATA_W(8), .N_OUT(3)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (d3_in_valid),
    .in_ready  (d3_in_ready),
    .in_data   (d3_in_data),
    .in_sel    (d3_in_sel),
    .out_valid (d3_out_valid),
    .out_ready (d3_out_ready),
    .out_data  (d3_out_data),
    .sel_err   (d3_sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: each channel is a FIFO of at most one word; last loaded word is what out_data shows.
  logic [7:0] m_q    [4][$];
  logic [7:0] m_last [4];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_q[i].delete();
        m_last[i] <= 8'h00;
      end
    end else begin
      // Pops first; a slot that pops had its consumer ready, so acceptance is unchanged.
      for (int i = 0; i < 4; i++) begin
        if (m_q[i].size() != 0 && out_ready[i]) void'(m_q[i].pop_front());
      end
      if (in_valid && (m_q[in_sel].size() == 0 || out_ready[in_sel])) begin
        m_q[in_sel].push_back(in_data);
        m_last[in_sel] <= in_data;
      end
    end
  end

  task automatic compare_model();
    logic [3:0]  ev;
    logic [31:0] ed;
    logic        er;
    for (int i = 0; i < 4; i++) begin
      ev[i]          = (m_q[i].size() != 0);
      ed[i*8 +: 8]   = m_last[i];
    end
    er = (m_q[in_sel].size() == 0) || out_ready[in_sel];
    check("model_out_valid", {28'd0, out_valid}, {28'd0, ev});
    check("model_out_data", out_data, ed);
    check("model_in_ready", {31'd0, in_ready}, {31'd0, er});
    check("model_sel_err", {31'd0, sel_err}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (chk_en) compare_model();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    chk_en = 1'b0;
    rst    = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; in_sel = 2'd0; out_ready = 4'hF;
    d3_in_valid = 1'b0; d3_in_data = 8'h00; d3_in_sel = 2'd0; d3_out_ready = 3'b000;
    #2 rst = 1'b1;
    #1;
    chk_en = 1'b1;
    check("rst_out_valid", {28'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_sel_err", {31'd0, sel_err}, 32'd0);
    check("rst_d3_out_valid", {29'd0, d3_out_valid}, 32'd0);
    check("rst_d3_out_data", {8'd0, d3_out_data}, 32'd0);
    step();
    rst = 1'b0;

    // Back-to-back words to each channel with all consumers ready.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_sel   = 2'(i);
      in_data  = 8'hA0 + 8'(i);
      #1 check("t1_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      check("t1_out_valid", {28'd0, out_valid}, 32'd1 << i);
      check("t1_out_data", {24'd0, out_data[i*8 +: 8]}, 32'hA0 + 32'(i));
    end
    in_valid = 1'b0;
    step();
    check("t1_drained", {28'd0, out_valid}, 32'd0);

    // Backpressure on channel 2 while channel 1 keeps flowing.
    out_ready = 4'b1011;
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h11;
    #1 check("t2_first_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("t2_hold_valid", {28'd0, out_valid}, 32'b0100);
    check("t2_hold_data", {24'd0, out_data[23:16]}, 32'h11);
    in_data = 8'h22;
    #1 check("t2_blocked", {31'd0, in_ready}, 32'd0);
    step();
    check("t2_stable", {24'd0, out_data[23:16]}, 32'h11);
    in_sel = 2'd1; in_data = 8'h33;
    #1 check("t2_other_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("t2_both_valid", {28'd0, out_valid}, 32'b0110);
    check("t2_ch1_data", {24'd0, out_data[15:8]}, 32'h33);
    in_sel = 2'd2; in_data = 8'h22; out_ready = 4'hF;
    #1 check("t2_passthru_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("t2_no_bubble", {28'd0, out_valid}, 32'b0100);
    check("t2_new_data", {24'd0, out_data[23:16]}, 32'h22);
    in_valid = 1'b0;
    step();
    check("t2_drained", {28'd0, out_valid}, 32'd0);

    // Out-of-range select on the 3-channel instance.
    d3_in_valid = 1'b1; d3_in_sel = 2'd3; d3_in_data = 8'h55;
    #1 check("t3_ready", {31'd0, d3_in_ready}, 32'd1);
    step();
    d3_in_valid = 1'b0;
    check("t3_sel_err", {31'd0, d3_sel_err}, 32'd1);
    check("t3_no_valid", {29'd0, d3_out_valid}, 32'd0);
    step();
    check("t3_err_pulse", {31'd0, d3_sel_err}, 32'd0);
    d3_in_valid = 1'b1; d3_in_sel = 2'd2; d3_in_data = 8'h66;
    step();
    d3_in_data = 8'h77;
    #1 check("t3_full_blocked", {31'd0, d3_in_ready}, 32'd0);
    check("t3_ch2_valid", {29'd0, d3_out_valid}, 32'b100);
    check("t3_ch2_data", {24'd0, d3_out_data[23:16]}, 32'h66);
    check("t3_no_err", {31'd0, d3_sel_err}, 32'd0);
    d3_in_valid = 1'b0;

    // Asynchronous reset with a word sitting in slot 0.
    out_ready = 4'h0;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h7E;
    step();
    in_valid = 1'b0;
    check("t4_filled", {28'd0, out_valid}, 32'd1);
    check("t4_fill_data", {24'd0, out_data[7:0]}, 32'h7E);
    #2 rst = 1'b1;
    #1;
    check("t4_async_valid", {28'd0, out_valid}, 32'd0);
    check("t4_async_data", out_data, 32'd0);
    step();
    rst = 1'b0;
    out_ready = 4'hF;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h01;
    step();
    in_valid = 1'b0;
    check("t4_after_valid", {28'd0, out_valid}, 32'd1);
    check("t4_after_data", {24'd0, out_data[7:0]}, 32'h01);

    // Random valid/ready stress against the model.
    for (int n = 0; n < 3000; n++) begin
      step();
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = 8'($urandom);
      out_ready = 4'($urandom);
    end
    step();
    in_valid  = 1'b0;
    out_ready = 4'hF;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
